// File: rtl/occupancy_counter_pkg.sv
// Shared constants and counting helpers for the occupancy counter and its grant arbiter.
package occ_pkg;

    localparam int unsigned MAX_GATES         = 32;
    localparam int unsigned CAP_DEFAULT       = 15;
    localparam int unsigned NEAR_FULL_DEFAULT = 12;

    function automatic int unsigned popcount(input logic [MAX_GATES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_GATES; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Set bits strictly below idx, saturated at cap.
    function automatic int unsigned capped_prefix(input logic [MAX_GATES-1:0] v,
                                                  input int idx,
                                                  input int unsigned cap);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_GATES; i++) begin
            if (i < idx && v[i]) n++;
        end
        return (n > cap) ? cap : n;
    endfunction

endpackage

// File: rtl/occupancy_counter_if.sv
// Gate event / status bundle between the gate sensor logic and the occupancy counter.
// The peak signal exists only when OCC_PEAK_EN is defined.
interface occ_if #(
    parameter int unsigned N_GATES = 2,
    parameter int unsigned CAP     = occ_pkg::CAP_DEFAULT
);
    localparam int unsigned CNT_W = $clog2(CAP + 1);

    logic [N_GATES-1:0] enter_req;
    logic [N_GATES-1:0] exit_evt;
    logic               clr_err;
    logic [N_GATES-1:0] enter_gnt;
    logic [N_GATES-1:0] enter_deny;
    logic [CNT_W-1:0]   cnt;
    logic               full;
    logic               empty;
    logic               near_full;
    logic               underflow;
`ifdef OCC_PEAK_EN
    logic [CNT_W-1:0]   peak;
`endif

    modport master (
        output enter_req, exit_evt, clr_err,
        input  enter_gnt, enter_deny, cnt, full, empty, near_full, underflow
`ifdef OCC_PEAK_EN
        , input peak
`endif
    );

    modport slave (
        input  enter_req, exit_evt, clr_err,
        output enter_gnt, enter_deny, cnt, full, empty, near_full, underflow
`ifdef OCC_PEAK_EN
        , output peak
`endif
    );

endinterface

// File: rtl/occupancy_counter_grant_arb.sv
// Fixed-priority grant allocator: lane 0 first, at most `space` grants per cycle.
module occ_grant_arb
    import occ_pkg::*;
#(
    parameter int unsigned N_GATES = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic [N_GATES-1:0] enter_req,
    input  logic [CNT_W-1:0]   space,
    output logic [N_GATES-1:0] enter_gnt,
    output logic [N_GATES-1:0] enter_deny
);

    logic [MAX_GATES-1:0] req_ext;
    int unsigned          space_i;

    // Lanes below i are all granted until space runs out, so counting the lower
    // requests (capped at space) equals counting the lower grants.
    always_comb begin
        req_ext   = MAX_GATES'(enter_req);
        space_i   = 32'(space);
        enter_gnt = '0;
        for (int i = 0; i < N_GATES; i++) begin
            enter_gnt[i] = enter_req[i] && (capped_prefix(req_ext, i, space_i) < space_i);
        end
        enter_deny = enter_req & ~enter_gnt;
    end

endmodule

// File: rtl/occupancy_counter.sv
// Vehicle occupancy counter: grants entries while space remains, tracks count/status flags
// and a sticky exit-underflow flag. Define OCC_PEAK_EN to add the peak-occupancy register.
module occupancy_counter
    import occ_pkg::*;
#(
    parameter int unsigned N_GATES   = 2,
    parameter int unsigned CAP       = CAP_DEFAULT,
    parameter int unsigned NEAR_FULL = NEAR_FULL_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    occ_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(CAP + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               near_full_q, near_full_d;
    logic               underflow_q, underflow_d;
    logic [CNT_W-1:0]   space;
    logic [N_GATES-1:0] gnt;
    logic [N_GATES-1:0] deny;
    int unsigned        n_enter;
    int unsigned        n_exit_req;
    int unsigned        n_exit;
    int unsigned        avail;
    logic               drop;

    // Zero space while in reset keeps every grant low; exits never add space this cycle.
    always_comb begin
        space = reset ? '0 : (CNT_W'(CAP) - cnt_q);
    end

    occ_grant_arb #(
        .N_GATES (N_GATES),
        .CNT_W   (CNT_W)
    ) u_arb (
        .enter_req  (bus.enter_req),
        .space      (space),
        .enter_gnt  (gnt),
        .enter_deny (deny)
    );

    always_comb begin
        n_enter     = popcount(MAX_GATES'(gnt));
        n_exit_req  = popcount(MAX_GATES'(bus.exit_evt));
        avail       = 32'(cnt_q) + n_enter;
        drop        = n_exit_req > avail;
        n_exit      = drop ? avail : n_exit_req;
        cnt_d       = CNT_W'(avail - n_exit);
        full_d      = (cnt_d == CNT_W'(CAP));
        empty_d     = (cnt_d == '0);
        near_full_d = (32'(cnt_d) >= NEAR_FULL);
        underflow_d = underflow_q;
        if (bus.clr_err) underflow_d = 1'b0;
        if (drop)        underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            near_full_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            near_full_q <= near_full_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef OCC_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = (cnt_d > peak_q) ? cnt_d : peak_q;
    end

    always_ff @(posedge clk) begin
        if (reset) peak_q <= '0;
        else       peak_q <= peak_d;
    end

    assign bus.peak = peak_q;
`endif

    assign bus.enter_gnt  = gnt;
    assign bus.enter_deny = deny;
    assign bus.cnt        = cnt_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.near_full  = near_full_q;
    assign bus.underflow  = underflow_q;

endmodule

// File: doc/occupancy_counter.md
# occupancy_counter

Multi-gate vehicle occupancy counter for the access-control datapath. It accepts per-gate enter and exit events from the gate sensors and grants entries only while spaces remain. It tracks the current vehicle count with full, empty and near-full status, and flags exit events that would drive the count below zero. It sits between the gate sensor/FSM logic and the display and barrier control.

## Interface
Parameters:
- N_GATES, 2, number of gate lanes; each lane has one enter and one exit sensor.
- CAP, 15, lot capacity in vehicles; ≥1.
- NEAR_FULL, 12, threshold for the near_full flag; must satisfy NEAR_FULL ≤ CAP.
- CNT_W, $clog2(CAP+1), count width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enter_req  in  N_GATES  per-lane single-cycle enter request (sensor event).
- exit_evt  in  N_GATES  per-lane single-cycle exit event.
- clr_err  in  1  clears the sticky underflow flag.
- enter_gnt  out  N_GATES  combinational grant; barrier opens for the granted lane.
- enter_deny  out  N_GATES  combinational; request present but not granted.
- cnt  out  CNT_W  registered current occupancy.
- full  out  1  registered; cnt == CAP.
- empty  out  1  registered; cnt == 0.
- near_full  out  1  registered; cnt ≥ NEAR_FULL.
- underflow  out  1  registered, sticky; an exit was dropped at count 0.
- peak  out  CNT_W  registered maximum of cnt since reset (only with OCC_PEAK_EN).

## Operation
- space = CAP − cnt, computed from the registered count. Same-cycle exits do not free space in that cycle.
- Grant allocation: at most `space` requests are granted per cycle, in fixed priority from lane 0 upward.
  - enter_gnt[i] = enter_req[i] AND (number of granted lanes below i) < space.
  - enter_deny = enter_req AND NOT enter_gnt.
  - Denied requests are dropped, not queued; the gate FSM re-requests if needed.
- Exits are always accepted up to the current count:
  - n_exit = min(popcount(exit_evt), cnt + n_enter).
  - Excess exits are dropped and set underflow.
- Next count: cnt_next = cnt + popcount(enter_gnt) − n_exit. The result is always in [0, CAP]; there is no wrap-around.
- Simultaneous enter and exit on the same lane are both processed.
- Flags are derived from cnt_next and registered alongside cnt.
- underflow: set when any exit is dropped. clr_err clears it; if a new underflow occurs in the same cycle as clr_err, the set wins.
- reset (synchronous) values: cnt=0, empty=1, full=0, near_full=0, underflow=0, peak=0.
  - Reset has priority over every event in that cycle.
  - Grants are forced to 0 while reset is high.

## Timing
- enter_gnt and enter_deny: zero latency, same cycle as enter_req.
- cnt, flags and peak reflect a cycle's events after the next rising edge (1-cycle latency).
- Events are pulses: a held input counts once per cycle it is high.

## Configuration
- OCC_PEAK_EN defined: the peak output exists. peak ← max(peak, cnt_next) each cycle, and resets to 0.
- OCC_PEAK_EN undefined: the peak port and register are absent; all other behaviour is identical.

## Structure
- Shared package occ_pkg holds:
  - the popcount function;
  - a capped-prefix-count function used for grant allocation;
  - the default constants (CAP, NEAR_FULL defaults).
- Sub-module occ_grant_arb: the combinational fixed-priority capped grant logic (enter_req, space → enter_gnt, enter_deny).
- The top level holds the count register, flags, underflow and peak.

## Test plan
Default parameters (N_GATES=2, CAP=15, NEAR_FULL=12) unless stated.
- Reset, then 12 single enter_req[0] pulses → cnt=12. near_full rises after the 12th edge; empty=0.
- cnt=14, enter_req=2'b11 → enter_gnt=2'b01, enter_deny=2'b10. Next cycle cnt=15, full=1.
- cnt=15, enter_req=2'b01 and exit_evt=2'b01 in the same cycle → gnt=0, deny=1 (space uses the registered count). cnt=14 next.
- cnt=1, exit_evt=2'b11 → cnt=0, empty=1, underflow=1. Then clr_err → underflow=0.
- cnt=5, enter_req=2'b11 and exit_evt=2'b11 → both granted, cnt stays 5. Then reset asserted together with enter_req=2'b11 → gnt=0, cnt=0.
- With OCC_PEAK_EN: enter to 9, exit to 3 → peak=9. Without OCC_PEAK_EN: build elaborates with no peak port.
